// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-addressed data memory behind a request/response handshake.
//
// The memory is organised as DATA_W-bit rows of bytes. Each request is
// captured on its handshake edge. It then waits a fixed WAIT cycles and is
// performed in a single edge. The response is held until the consumer takes it.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. req_ready is high only while idle, so at
// most one request is in flight. Once rsp_valid is high, it stays high with
// rsp_rdata/rsp_err frozen until the edge where rsp_ready is also high.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 doubleword (DATA_W=64)
//   req_unsigned       load zero-extends when 1, sign-extends when 0
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   rsp_valid/ready    response handshake
//   rsp_rdata          right-aligned, extended load data (0 for stores/errors)
//   rsp_err            request was misaligned or illegal
//   o_dbg_state        current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module data_memory_hs #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        o_dbg_state
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = (DATA_W == 64) ? 3 : 2;
    localparam int ROW_W  = ADDR_W - LANE_W;
    localparam int ROWS   = 2 ** ROW_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    // Memory contents are deliberately never reset.
    logic [DATA_W-1:0]   r_mem [ROWS];

    logic [LANE_W-1:0]   w_lane;
    logic [ROW_W-1:0]    w_row;
    logic [3:0]          w_nbytes;
    logic                w_err;
    logic                w_do_access;
    logic                w_wr_en;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wshift;
    logic [DATA_W-1:0]   w_rshift;
    logic                w_sign;
    logic [7:0]          w_fill;
    logic [DATA_W-1:0]   w_load;

    assign w_lane      = r_addr[LANE_W-1:0];
    assign w_row       = r_addr[ADDR_W-1:LANE_W];
    assign w_nbytes    = 4'd1 << r_size;
    assign w_do_access = (r_state == S_ACCESS) && (r_cnt == 3'd0);
    assign w_wr_en     = w_do_access && r_we && !w_err;

    // Alignment / legality of the captured request.
    always_comb begin
        w_err = 1'b0;
        case (r_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = r_addr[0];
            2'b10:   w_err = |r_addr[1:0];
            default: w_err = (DATA_W != 64) || (|r_addr[2:0]);
        endcase
    end

    // Byte enables cover lanes [lane, lane+nbytes) of the addressed row.
    always_comb begin
        w_be = '0;
        for (int l = 0; l < NB; l++) begin
            w_be[l] = (l >= int'(w_lane)) && (l < int'(w_lane) + int'(w_nbytes));
        end
    end

    assign w_wshift = r_wdata << {w_lane, 3'b000};

    // Load path: shift the addressed bytes down, then fill the upper bytes
    // with the sign of the extracted field or with zeros.
    always_comb begin
        w_rshift = r_mem[w_row] >> {w_lane, 3'b000};
        case (r_size)
            2'b00:   w_sign = w_rshift[7];
            2'b01:   w_sign = w_rshift[15];
            2'b10:   w_sign = w_rshift[31];
            default: w_sign = w_rshift[DATA_W-1];
        endcase
        w_fill = (!r_uns && w_sign) ? 8'hFF : 8'h00;
        w_load = '0;
        for (int l = 0; l < NB; l++) begin
            w_load[8*l +: 8] = (l < int'(w_nbytes)) ? w_rshift[8*l +: 8] : w_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int l = 0; l < NB; l++) begin
                if (w_be[l]) begin
                    r_mem[w_row][8*l +: 8] <= w_wshift[8*l +: 8];
                end
            end
        end
    end

    // Control FSM. Reset forces IDLE asynchronously, so an in-flight request
    // is aborted before its access edge and any pending response is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 3'(WAIT);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? '0 : w_load;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_hs.sv
module tb_data_memory_hs;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int WAIT   = 1;
  localparam int CLK_P  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        dbg_state;

  data_memory_hs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #(CLK_P/2) clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    longint      t_acc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [2**ADDR_W];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array, little-endian, alignment by modulo.
  function automatic exp_t model(input bit we, input logic [1:0] size, input bit uns,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          n;
    logic [31:0] v;
    e = '0;
    n = 1 << size;
    v = 32'h0;
    if (size == 2'b11 || (int'(addr) % n) != 0) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
      if (!uns && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input bit use_exp, input logic [31:0] erd, input bit eerr);
    exp_t e;
    int   guard;
    guard = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 200);
    chk("req_accept", {63'd0, req_ready}, 64'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(we, size, uns, addr, wdata);
    if (use_exp) begin
      e.rdata = erd;
      e.err   = eerr;
    end
    e.t_acc = $time;
    exp_q.push_back(e);
    #1;
    // Scramble the request bus; the captured request must not follow it.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_q.size() != 0 || !req_ready) && guard < 500);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- response backpressure ----------------
  always @(posedge clk) begin
    #2;
    case (stall_mode)
      0:       rsp_ready = ($urandom_range(0, 2) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // ---------------- monitor: pop on response handshake ----------------
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  // ---------------- monitor: latency and hold stability ----------------
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic [DATA_W-1:0] held_rdata = '0;
  logic              held_err = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("rsp_without_req", 64'd1, 64'd0);
      else chk("latency", 64'($time - exp_q[0].t_acc), 64'((WAIT+1)*CLK_P + CLK_P/2));
    end
    if (rst_n && rsp_valid && prev_valid && !prev_ready) begin
      chk("hold_rdata", 64'(rsp_rdata), 64'(held_rdata));
      chk("hold_err", {63'd0, rsp_err}, {63'd0, held_err});
    end
    prev_valid = rsp_valid;
    prev_ready = rsp_ready;
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
  end

  // ---------------- watchdog ----------------
  initial begin
    #(50000 * CLK_P);
    chk("watchdog_timeout", 64'd1, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int            guard;
    exp_t          e;
    logic [1:0]    sz;
    logic [ADDR_W-1:0] a;

    // Reset values while rst_n is low.
    #3;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Preload the low 256 bytes so every later load has known contents.
    for (int i = 0; i < 64; i++) issue(1'b1, 2'b10, 1'b0, ADDR_W'(i*4), $urandom, 1'b0, 32'd0, 1'b0);
    wait_idle();

    // Directed sequence with known values.
    issue(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 11'h013, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 11'h013, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 11'h012, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 11'h012, 32'h0, 1'b1, 32'h0000DEAD, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 11'h011, 32'hAAAAAA55, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 11'h011, 32'h12345678, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 11'h012, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 11'h010, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 11'h018, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 11'h018, 32'h0, 1'b0, 32'h0, 1'b0);
    wait_idle();

    // Backpressure: response held for 5+ cycles, request side blocked.
    stall_mode = 2'd1;
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 50);
    chk("stall_rsp_seen", {63'd0, rsp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    end
    stall_mode = 2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("release_req_ready", {63'd0, req_ready}, 64'd1);
    wait_idle();

    // Reset during ACCESS of a store: aborted, memory untouched.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 11'h020; req_wdata = 32'h13579BDF;
    @(negedge clk);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("abort_rsp_err", {63'd0, rsp_err}, 64'd0);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    issue(1'b0, 2'b10, 1'b0, 11'h020, 32'h0, 1'b0, 32'h0, 1'b0);
    wait_idle();

    // Randomized traffic with random backpressure.
    stall_mode = 0;
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ADDR_W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~(ADDR_W'((1 << sz) - 1));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 32'h0, 1'b0);
    end
    stall_mode = 2;
    wait_idle();

    e = '0;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(e.t_acc));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
